key_sequence_checker: RTL and testbench
=======================================

KEY_SEQUENCE_CHECKER -- requirements
Module: key_sequence_checker

Interface
REQ-001 Parameter CODE_LEN, default 4: number of symbols in the unlock code, 1..8.
REQ-002 Parameter CODE, default 8'b0000_0110: expected symbols; bit i is symbol i (0 = short, 1 = long); bit 0 is entered first; bits at or above CODE_LEN are ignored.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: maximum idle gap between symbols while collecting.
REQ-004 Parameter UNLOCK_CYCLES, default 16: duration of the UNLOCK assertion.
REQ-005 Parameter LOCKOUT_CYCLES, default 4096: lockout duration; used only with LOCKOUT_EN.
REQ-006 CLK  input  1: single clock; all state updates on the rising edge.
REQ-007 RST  input  1: asynchronous, active-low reset.
REQ-008 SHORT_IN  input  1: one-cycle pulse from the pulse-width classifier; a short press ended.
REQ-009 LONG_IN  input  1: one-cycle pulse from the pulse-width classifier; a long press ended.
REQ-010 UNLOCK  output  1: high for UNLOCK_CYCLES cycles after a correct code.
REQ-011 ERROR  output  1: one-cycle pulse on a wrong symbol or a timeout.
REQ-012 LOCKED  output  1: high while in lockout.
REQ-013 SYM_CNT  output  4: number of correct symbols accepted so far in the current attempt.

Function
REQ-014 States: IDLE, COLLECT, OPEN, LOCKOUT. All outputs are registered, so each response appears 1 cycle after the triggering input edge.
REQ-015 Symbol event: exactly one of SHORT_IN or LONG_IN is high. Both high in the same cycle is an invalid symbol and is treated as a mismatch.
REQ-016 IDLE with a symbol event: compare against CODE[0]. On a match with CODE_LEN==1, go to OPEN. On a match otherwise, go to COLLECT with SYM_CNT=1. On a mismatch, pulse ERROR and stay in IDLE with SYM_CNT=0.
REQ-017 COLLECT with a symbol event: compare against CODE[SYM_CNT].
- Match with SYM_CNT==CODE_LEN-1: go to OPEN.
- Match otherwise: increment SYM_CNT.
- Mismatch: pulse ERROR, clear SYM_CNT, go to IDLE.
REQ-018 COLLECT timeout counter: cleared on every symbol event. If it reaches TIMEOUT_CYCLES with no event, pulse ERROR, clear SYM_CNT, go to IDLE. A symbol arriving in the same cycle as the timeout takes priority and is evaluated.
REQ-019 OPEN: UNLOCK is high for exactly UNLOCK_CYCLES cycles, then the block returns to IDLE. SYM_CNT is cleared on entry to OPEN. Symbol events are ignored and never raise ERROR.
REQ-020 In IDLE, inputs with no symbol event hold all state. No timeout runs in IDLE.
REQ-021 UNLOCK and ERROR are never high in the same cycle.

Reset
REQ-022 While RST=0, the block asynchronously enters IDLE: UNLOCK=0, ERROR=0, LOCKED=0, SYM_CNT=0, all counters and the fail count cleared.
REQ-023 Asserting reset mid-attempt, mid-OPEN or mid-LOCKOUT aborts that activity immediately.
REQ-024 On the first rising edge after RST goes high, the block evaluates inputs normally from IDLE.

Configuration
REQ-025 Macro KEY_SEQUENCE_CHECKER_LOCKOUT_EN.
REQ-026 Defined: a 2-bit consecutive-failure count increments on each ERROR and clears on entry to OPEN.
- The third consecutive ERROR enters LOCKOUT instead of IDLE, with LOCKED=1 for LOCKOUT_CYCLES cycles.
- All symbols are ignored during LOCKOUT.
- On exit from LOCKOUT: go to IDLE, clear the fail count, set LOCKED=0.
REQ-027 Not defined: no LOCKOUT state and no fail count; LOCKED is tied to 0; unlimited retries.

Verification
REQ-028 Defaults, sequence S,L,L,S at 10-cycle gaps -> SYM_CNT steps 1,2,3; UNLOCK rises 1 cycle after the 4th pulse and stays high 16 cycles; ERROR stays 0.
REQ-029 Sequence S,S -> ERROR pulses 1 cycle after the 2nd pulse; SYM_CNT returns to 0; a following correct S,L,L,S unlocks.
REQ-030 S, then no input for 1024 cycles -> ERROR pulses once; state is IDLE; SYM_CNT=0.
REQ-031 SHORT_IN=LONG_IN=1 in the same cycle from IDLE -> ERROR pulse; UNLOCK stays 0.
REQ-032 With LOCKOUT_EN defined, three wrong first symbols -> LOCKED=1 for 4096 cycles; a correct code entered during lockout gives no UNLOCK; the same code after lockout unlocks.
REQ-033 Reset pulled low after S,L,L -> all outputs 0 immediately; after release, L,S gives no UNLOCK.

Source files
------------

// File: rtl/key_sequence_checker.sv
// -----------------------------------------------------------------------------
// key_sequence_checker
//
// Purpose: checks a stream of short/long press symbols against a fixed unlock
// code. A complete correct code raises UNLOCK for UNLOCK_CYCLES cycles. A wrong
// symbol, or an idle gap of TIMEOUT_CYCLES while part of the code has been
// entered, pulses ERROR and restarts the attempt from the first symbol.
//
// Optional feature (macro KEY_SEQUENCE_CHECKER_LOCKOUT_EN):
//   When defined, the third consecutive ERROR enters a lockout state. LOCKED is
//   high for LOCKOUT_CYCLES cycles, and every symbol is ignored during that
//   time. When undefined, there is no lockout, retries are unlimited, and
//   LOCKED is tied low.
//
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   asynchronous reset, active low
//   SHORT_IN     in   one-cycle pulse: a short press ended
//   LONG_IN      in   one-cycle pulse: a long press ended
//   UNLOCK       out  high for UNLOCK_CYCLES cycles after a correct code
//   ERROR        out  one-cycle pulse on a wrong symbol or a timeout
//   LOCKED       out  high while in lockout
//   SYM_CNT      out  correct symbols accepted so far in this attempt
//   dbg_state_o  out  current FSM state (0 IDLE, 1 COLLECT, 2 OPEN, 3 LOCKOUT)
//
// All outputs are registered, so each response appears one cycle after the
// input edge that caused it.
// -----------------------------------------------------------------------------
module key_sequence_checker #(
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [7:0]  CODE           = 8'b0000_0110,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned UNLOCK_CYCLES  = 16,
  parameter int unsigned LOCKOUT_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SHORT_IN,
  input  logic       LONG_IN,
  output logic       UNLOCK,
  output logic       ERROR,
  output logic       LOCKED,
  output logic [3:0] SYM_CNT,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_OPEN    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_e;

  // One counter serves the timeout in COLLECT, the OPEN duration and the
  // LOCKOUT duration. These uses never overlap, so it is sized for the largest.
  localparam int unsigned MAX_TU  = (TIMEOUT_CYCLES > UNLOCK_CYCLES) ? TIMEOUT_CYCLES : UNLOCK_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_TU > LOCKOUT_CYCLES) ? MAX_TU : LOCKOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] UNL_LAST = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [3:0]       LAST_IDX = 4'(CODE_LEN - 1);

  state_e           state_q, state_d;
  logic [3:0]       sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unlock_q;
  logic             error_q;
  logic             err_ev;

  // The code is zero-extended to 16 entries so that the full 4-bit SYM_CNT can
  // index it directly. Bits at or above CODE_LEN are never reached.
  logic [15:0] code_ext;
  assign code_ext = {8'h00, CODE};

  // A symbol event is any press pulse. It matches only when exactly one
  // input is high and that symbol equals the expected code bit.
  logic sym_ev;
  logic match;
  assign sym_ev = SHORT_IN | LONG_IN;
  assign match  = (SHORT_IN ^ LONG_IN) && (LONG_IN == code_ext[sym_cnt_q]);

`ifdef KEY_SEQUENCE_CHECKER_LOCKOUT_EN
  localparam logic [CNT_W-1:0] LCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  logic [1:0] fail_q, fail_d;
  logic       locked_q;
`endif

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    cnt_d     = cnt_q;
    err_ev    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sym_ev) begin
          if (match) begin
            cnt_d = '0;
            if (LAST_IDX == 4'd0) begin
              state_d   = S_OPEN;
              sym_cnt_d = 4'd0;
            end else begin
              state_d   = S_COLLECT;
              sym_cnt_d = 4'd1;
            end
          end else begin
            err_ev = 1'b1;
          end
        end
      end

      S_COLLECT: begin
        // A symbol in the same cycle as the timeout is evaluated first.
        if (sym_ev) begin
          cnt_d = '0;
          if (match) begin
            if (sym_cnt_q == LAST_IDX) begin
              state_d   = S_OPEN;
              sym_cnt_d = 4'd0;
            end else begin
              sym_cnt_d = sym_cnt_q + 4'd1;
            end
          end else begin
            err_ev = 1'b1;
          end
        end else if (cnt_q == TMO_LAST) begin
          err_ev = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_OPEN: begin
        // Symbols are ignored while open.
        if (cnt_q == UNL_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
`ifdef KEY_SEQUENCE_CHECKER_LOCKOUT_EN
        if (cnt_q == LCK_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        state_d = S_IDLE;
        cnt_d   = '0;
`endif
      end
    endcase

    if (err_ev) begin
      state_d   = S_IDLE;
      sym_cnt_d = 4'd0;
      cnt_d     = '0;
    end

`ifdef KEY_SEQUENCE_CHECKER_LOCKOUT_EN
    fail_d = fail_q;
    if (err_ev) begin
      fail_d = fail_q + 2'd1;
      // This error is the third in a row: it goes to lockout instead of idle.
      if (fail_q == 2'd2) begin
        state_d = S_LOCKOUT;
      end
    end
    if ((state_d == S_OPEN) && (state_q != S_OPEN)) begin
      fail_d = 2'd0;
    end
    if ((state_q == S_LOCKOUT) && (state_d == S_IDLE)) begin
      fail_d = 2'd0;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      sym_cnt_q <= 4'd0;
      cnt_q     <= '0;
      unlock_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      cnt_q     <= cnt_d;
      unlock_q  <= (state_d == S_OPEN);
      error_q   <= err_ev;
    end
  end

`ifdef KEY_SEQUENCE_CHECKER_LOCKOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fail_q   <= 2'd0;
      locked_q <= 1'b0;
    end else begin
      fail_q   <= fail_d;
      locked_q <= (state_d == S_LOCKOUT);
    end
  end
  assign LOCKED = locked_q;
`else
  assign LOCKED = 1'b0;
`endif

  assign UNLOCK      = unlock_q;
  assign ERROR       = error_q;
  assign SYM_CNT     = sym_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_key_sequence_checker.sv
// -----------------------------------------------------------------------------
// tb_key_sequence_checker
//
// Directed-vector bench for key_sequence_checker with default parameters
// (code S,L,L,S; timeout 1024; unlock 16; lockout 4096). Inputs are driven on
// the falling edge. Outputs are sampled on the falling edge, half a cycle after
// the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_key_sequence_checker;

  // ---------------- clock / reset ----------------
  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       short_in = 1'b0;
  logic       long_in  = 1'b0;
  logic       unlock;
  logic       error;
  logic       locked;
  logic [3:0] sym_cnt;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_sequence_checker dut (
    .CLK         (clk),
    .RST         (rst_n),
    .SHORT_IN    (short_in),
    .LONG_IN     (long_in),
    .UNLOCK      (unlock),
    .ERROR       (error),
    .LOCKED      (locked),
    .SYM_CNT     (sym_cnt),
    .dbg_state_o (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge. The symbol is sampled on the next rising edge and
  // the task returns at the falling edge after that, when the response is visible.
  task automatic pulse(input logic s, input logic l);
    short_in = s;
    long_in  = l;
    @(negedge clk);
    short_in = 1'b0;
    long_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
  endtask

  // Enters S,L,L,S with 'gap' cycles between successive pulses.
  task automatic enter_code(input string tag, input int gap);
    logic [3:0] code;
    code = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      pulse(~code[i], code[i]);
      check({tag, "_err"}, error, 1'b0);
      if (i < 3) begin
        check({tag, "_sym"}, sym_cnt, i + 1);
        check({tag, "_unl_lo"}, unlock, 1'b0);
        idle(gap - 1);
      end else begin
        check({tag, "_unl_hi"}, unlock, 1'b1);
        check({tag, "_sym_clr"}, sym_cnt, 4'd0);
      end
    end
  endtask

  // Counts the cycles UNLOCK remains high from the current falling edge.
  // It also reports whether ERROR was seen during that time.
  task automatic measure_unlock(output int n, output logic err_seen);
    n = 0;
    err_seen = 1'b0;
    while (unlock && n < 100) begin
      if (error) err_seen = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  // Watchdog: the stimulus below is far shorter than this limit.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    logic es;

    // Reset state.
    idle(3);
    check("rst_unlock", unlock, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_locked", locked, 1'b0);
    check("rst_sym", sym_cnt, 4'd0);
    check("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;

    // Correct code at 10-cycle gaps unlocks for 16 cycles.
    enter_code("main", 10);
    measure_unlock(n, es);
    check("main_unl_len", n, 16);
    check("main_no_err", es, 1'b0);
    check("main_unl_drop", unlock, 1'b0);
    check("main_state_idle", dbg_state, 2'd0);

    // S,S gives an error, then a correct code unlocks. Symbols sent while open are ignored.
    do_reset;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("ss_err", error, 1'b1);
    check("ss_sym", sym_cnt, 4'd0);
    check("ss_unl", unlock, 1'b0);
    idle(1);
    check("ss_err_1cyc", error, 1'b0);
    enter_code("retry", 1);
    pulse(1'b1, 1'b0);
    check("open_ign_err", error, 1'b0);
    check("open_ign_unl", unlock, 1'b1);
    pulse(1'b1, 1'b1);
    check("open_ign_both", error, 1'b0);
    check("open_ign_sym", sym_cnt, 4'd0);
    measure_unlock(n, es);
    check("open_remaining", n, 14);
    check("open_no_err", es, 1'b0);

    // Timeout after S with no further input.
    do_reset;
    pulse(1'b1, 1'b0);
    check("tmo_sym1", sym_cnt, 4'd1);
    n = 0;
    while (!error && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, 1024);
    check("tmo_sym", sym_cnt, 4'd0);
    check("tmo_state", dbg_state, 2'd0);
    check("tmo_unl", unlock, 1'b0);
    idle(1);
    check("tmo_err_1cyc", error, 1'b0);

    // A symbol that arrives in the same cycle as the timeout is evaluated.
    do_reset;
    pulse(1'b1, 1'b0);
    idle(1023);
    check("edge_pre_err", error, 1'b0);
    pulse(1'b0, 1'b1);
    check("edge_err", error, 1'b0);
    check("edge_sym", sym_cnt, 4'd2);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    check("edge_unl", unlock, 1'b1);
    measure_unlock(n, es);
    check("edge_unl_len", n, 16);

    // Invalid symbol (both inputs high) and wrong first symbol, starting from IDLE.
    do_reset;
    pulse(1'b1, 1'b1);
    check("both_idle_err", error, 1'b1);
    check("both_idle_unl", unlock, 1'b0);
    check("both_idle_sym", sym_cnt, 4'd0);
    pulse(1'b0, 1'b1);
    check("long_idle_err", error, 1'b1);
    check("long_idle_sym", sym_cnt, 4'd0);
    check("long_idle_state", dbg_state, 2'd0);

    // Invalid symbol during COLLECT.
    do_reset;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    check("both_col_err", error, 1'b1);
    check("both_col_sym", sym_cnt, 4'd0);
    check("both_col_state", dbg_state, 2'd0);

    // Reset partway through an attempt.
    do_reset;
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("mid_sym3", sym_cnt, 4'd3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sym", sym_cnt, 4'd0);
    check("arst_unl", unlock, 1'b0);
    check("arst_err", error, 1'b0);
    check("arst_lck", locked, 1'b0);
    check("arst_state", dbg_state, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse(1'b0, 1'b1);
    check("post_rst_l_err", error, 1'b1);
    pulse(1'b1, 1'b0);
    check("post_rst_s_sym", sym_cnt, 4'd1);
    check("post_rst_unl", unlock, 1'b0);

    // Reset while open.
    do_reset;
    enter_code("pre_open_rst", 2);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_open_unl", unlock, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check("arst_open_stay", unlock, 1'b0);

`ifdef KEY_SEQUENCE_CHECKER_LOCKOUT_EN
    // Three wrong symbols in a row start a lockout. A correct code entered during lockout is ignored.
    do_reset;
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("lk_two_err_unlocked", locked, 1'b0);
    pulse(1'b0, 1'b1);
    check("lk_third_err", error, 1'b1);
    check("lk_locked", locked, 1'b1);
    check("lk_state", dbg_state, 2'd3);
    begin
      logic [3:0] code;
      logic       bad;
      code = 4'b0110;
      bad  = 1'b0;
      n    = 0;
      while (locked && n < 5000) begin
        if (n > 0 && (unlock || error)) bad = 1'b1;
        if (n < 4) begin
          short_in = ~code[n];
          long_in  = code[n];
        end else begin
          short_in = 1'b0;
          long_in  = 1'b0;
        end
        @(negedge clk);
        n++;
      end
      short_in = 1'b0;
      long_in  = 1'b0;
      check("lk_len", n, 4096);
      check("lk_ignored", bad, 1'b0);
    end
    check("lk_exit_state", dbg_state, 2'd0);
    enter_code("lk_after", 1);
    measure_unlock(n, es);
    check("lk_after_len", n, 16);
`else
    // Without lockout, retries are unlimited.
    do_reset;
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("nolk_err", error, 1'b1);
    check("nolk_locked", locked, 1'b0);
    check("nolk_state", dbg_state, 2'd0);
    enter_code("nolk_retry", 1);
    measure_unlock(n, es);
    check("nolk_unl_len", n, 16);
`endif

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
